// File: rtl/mem_arbiter_if.sv
// Port bundle of the two-port RAM arbiter: CPU and DMA request ports plus the RAM side.
// Purely wires; no timing of its own.
// Requests are level-held by the requesters until their done pulse is returned.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        dma_req;
  logic        dma_wr;
  logic [12:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        cpu_gnt;
  logic        dma_gnt;
  logic        cpu_done;
  logic        dma_done;
  logic [7:0]  rdata;
  logic        ram_cs;
  logic        ram_rd;
  logic        ram_wr;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    input  ram_rdata,
    output cpu_gnt, dma_gnt, cpu_done, dma_done, rdata,
    output ram_cs, ram_rd, ram_wr, ram_addr, ram_wdata
  );

  // Requester / RAM environment side
  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    output ram_rdata,
    input  cpu_gnt, dma_gnt, cpu_done, dma_done, rdata,
    input  ram_cs, ram_rd, ram_wr, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM between a CPU port and a DMA port.
// Latency: request seen in IDLE -> SETUP, STROBE, done pulse 3 cycles later; 4 cycles per access.
// Backpressure: the losing requester simply holds req high and is served from the next IDLE.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t      state;
  logic        last_dma;   // 1 = DMA owned the RAM last (also the current owner during an access)
  logic        lat_wr;
  logic        cpu_gnt;
  logic        dma_gnt;
  logic        cpu_done;
  logic        dma_done;
  logic        ram_cs;
  logic        ram_rd;
  logic        ram_wr;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  rdata;
  logic        pick_dma;

  // DMA wins when it is the only requester, or when both ask and CPU went last
  assign pick_dma = bus.dma_req & (~bus.cpu_req | ~last_dma);

  // Access sequencer; every output is a register updated on the state transition into its cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_dma  <= 1'b1;
      lat_wr    <= 1'b0;
      cpu_gnt   <= 1'b0;
      dma_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      ram_cs    <= 1'b0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
      ram_addr  <= 13'h0000;
      ram_wdata <= 8'h00;
      rdata     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            last_dma  <= pick_dma;
            lat_wr    <= pick_dma ? bus.dma_wr    : bus.cpu_wr;
            ram_addr  <= pick_dma ? bus.dma_addr  : bus.cpu_addr;
            ram_wdata <= pick_dma ? bus.dma_wdata : bus.cpu_wdata;
            cpu_gnt   <= ~pick_dma;
            dma_gnt   <= pick_dma;
            ram_cs    <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          ram_wr <= lat_wr;
          ram_rd <= ~lat_wr;
          state  <= STROBE;
        end
        STROBE: begin
          // Read data is only valid while ram_rd is high, so capture it on this edge
          if (ram_rd) begin
            rdata <= bus.ram_rdata;
          end
          ram_cs   <= 1'b0;
          ram_rd   <= 1'b0;
          ram_wr   <= 1'b0;
          cpu_done <= ~last_dma;
          dma_done <= last_dma;
          state    <= DONE;
        end
        DONE: begin
          cpu_done <= 1'b0;
          dma_done <= 1'b0;
          cpu_gnt  <= 1'b0;
          dma_gnt  <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_done  = cpu_done;
  assign bus.dma_done  = dma_done;
  assign bus.rdata     = rdata;
  assign bus.ram_cs    = ram_cs;
  assign bus.ram_rd    = ram_rd;
  assign bus.ram_wr    = ram_wr;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  single system clock; all state changes on posedge clk.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-003 cpu_req  input  1  CPU access request, level, held until cpu_done seen.
REQ-004 cpu_wr  input  1  CPU direction: 1 = write, 0 = read.
REQ-005 cpu_addr  input  13  CPU address.
REQ-006 cpu_wdata  input  8  CPU write data.
REQ-007 dma_req / dma_wr / dma_addr / dma_wdata  input  1/1/13/8  DMA port, same meaning as CPU port.
REQ-008 cpu_gnt / dma_gnt  output  1 each  port currently owns the RAM.
REQ-009 cpu_done / dma_done  output  1 each  one-cycle completion pulse to the owning port.
REQ-010 rdata  output  8  registered read data, valid in the done cycle, held until next read capture.
REQ-011 ram_cs  output  1  RAM chip select.
REQ-012 ram_rd / ram_wr  output  1 each  RAM read / write strobes.
REQ-013 ram_addr  output  13  registered RAM address.
REQ-014 ram_wdata  output  8  registered RAM write data.
REQ-015 ram_rdata  input  8  RAM read data, valid while ram_rd=1.

Function
REQ-016 FSM states: IDLE, SETUP, STROBE, DONE; all outputs registered.
REQ-017 IDLE: if any req=1 at posedge, select winner, latch its wr/addr/wdata, go SETUP; else stay IDLE.
REQ-018 Arbitration: single requester wins; both requesting -> port not granted last wins (round-robin).
REQ-019 last_owner register updates on every IDLE->SETUP transition.
REQ-020 SETUP: winner gnt=1, ram_cs=1, ram_addr/ram_wdata = latched values, ram_rd=ram_wr=0; next STROBE.
REQ-021 STROBE: gnt, ram_cs held; ram_wr=1 if latched wr=1 else ram_rd=1; next DONE.
REQ-022 STROBE read: ram_rdata captured into rdata at the STROBE->DONE edge.
REQ-023 DONE: winner done=1 for exactly one cycle, gnt still 1, ram_cs/ram_rd/ram_wr=0; next IDLE unconditionally.
REQ-024 Requester drops req at the edge ending its DONE cycle; a req still high in IDLE is a new request.
REQ-025 Latency: req seen in IDLE at edge N -> SETUP N+1, STROBE N+2, done in cycle N+3; 4 cycles minimum per access incl. IDLE.
REQ-026 Port inputs (wr/addr/wdata) ignored after latch; changes during SETUP/STROBE/DONE have no effect.
REQ-027 Non-owner gnt and done remain 0 at all times; never two gnt=1 simultaneously.
REQ-028 ram_rd and ram_wr never both 1; both 0 whenever ram_cs=0.
REQ-029 Write access leaves rdata unchanged.
REQ-030 Req of non-owner during an access is held pending, served from next IDLE by REQ-018.

Reset
REQ-031 rst=0: state=IDLE, all gnt/done/ram_cs/ram_rd/ram_wr=0, ram_addr=0, ram_wdata=0, rdata=0.
REQ-032 rst=0 sets last_owner=DMA so CPU wins the first simultaneous request.
REQ-033 Reset mid-access (SETUP/STROBE/DONE) aborts: no done pulse, strobes drop asynchronously, access lost.
REQ-034 After rst release, first posedge evaluates IDLE per REQ-017.

Verification
REQ-035 CPU read only: cpu_req=1, cpu_wr=0, addr=13'h0010, RAM[0x10]=8'hA5 -> cpu_gnt cycles N+1..N+3, ram_rd=1 at N+2, cpu_done=1 at N+3, rdata=8'hA5.
REQ-036 DMA write: dma_req=1, dma_wr=1, addr=13'h1FFF, wdata=8'h3C -> ram_wr=1 one cycle with ram_addr=13'h1FFF, ram_wdata=8'h3C, dma_done at N+3, rdata unchanged.
REQ-037 Simultaneous first requests after reset -> CPU served first, DMA served next, DMA done exactly 4 cycles after cpu_done.
REQ-038 Both requesters held continuously for 8 accesses -> grants alternate CPU,DMA,CPU,... with no port starved and never both gnt=1.
REQ-039 rst=0 asserted during STROBE of a CPU write -> ram_wr, cpu_gnt drop immediately, no cpu_done, state IDLE after release.
REQ-040 cpu_addr changed from 13'h0001 to 13'h0002 during STROBE -> ram_addr stays 13'h0001 for the access.
